dm_responder: RTL and testbench

//   Data-memory responder: the memory-side end of the CPU data port (byte address, write data,

---
 rtl/mem_pkg.sv | 30 +++
 rtl/dm_responder_if.sv | 32 +++
 rtl/dm_ram_be.sv | 44 ++++
 rtl/dm_responder.sv | 141 ++++++++++++++
 tb/tb_dm_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the data-memory responder: FSM state
//               encoding, word/byte-enable constants and the address error
//               check used on latched requests.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  BE_ALL     = 4'hF;
    localparam int unsigned WAIT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A byte address is bad when it is not word aligned or when it points
    // beyond the 2**aw-word RAM (any bit at or above aw+2 set).
    function automatic logic addr_err(input logic [31:0] a, input int unsigned aw);
        logic [31:0] hi;
        hi = a >> (aw + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder_if
// Description : Request/response bundle of the CPU data port.
//               master : req, we, addr, wdata, be  -> ; <- gnt, rvalid, rdata, err
//               slave  : mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata, err
    );

endinterface
`default_nettype wire

// File: rtl/dm_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : dm_ram_be
// Description : 2**ADDR_W x 32 word RAM with synchronous byte-enabled write,
//               asynchronous read on the access address and a second
//               asynchronous debug read port. Contents are not reset.
// Ports       : clk_i, we_i, addr_i, wdata_i, be_i, rdata_o,
//               dbg_addr_i, dbg_data_o
// Revision    : 1.0 - initial release
// ============================================================================
module dm_ram_be
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk_i,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] addr_i,
    input  wire logic [31:0]       wdata_i,
    input  wire logic [3:0]        be_i,
    output logic      [31:0]       rdata_o,
    input  wire logic [ADDR_W-1:0] dbg_addr_i,
    output logic      [31:0]       dbg_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o    = mem_q[addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Memory-side end of the CPU data port. Accepts one word
//               request at a time (req/gnt), waits WAIT cycles, then issues a
//               single-cycle rvalid with rdata/err. Writes commit on the edge
//               entering the response state.
// Ports       : clk_i, rst_ni (async, active low), bus (slave modport),
//               dbg_addr_i, dbg_data_o (combinational RAM peek)
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    dm_responder_if.slave          bus,
    input  wire logic [ADDR_W-1:0] dbg_addr_i,
    output logic      [31:0]       dbg_data_o
);

    localparam logic              NO_WAIT = (WAIT == 0);
    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'((WAIT > 0) ? (WAIT - 1) : 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              gnt;
    logic              accept;
    logic              enter_resp;
    logic              src_we;
    logic [31:0]       src_addr;
    logic [31:0]       src_wdata;
    logic [3:0]        src_be;
    logic              src_err;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    // gnt is gated by reset so it reads 0 while the FSM is held in IDLE.
    assign gnt    = (state_q == ST_IDLE) && rst_ni;
    assign accept = gnt && bus.req;

    // With WAIT=0 the response is entered on the accept edge itself, before
    // the latch holds the request, so the live bus fields are used then.
    always_comb begin
        src_we    = we_q;
        src_addr  = addr_q;
        src_wdata = wdata_q;
        src_be    = be_q;
        if (state_q == ST_IDLE) begin
            src_we    = bus.we;
            src_addr  = bus.addr;
            src_wdata = bus.wdata;
            src_be    = bus.be;
        end
    end

    assign src_err    = addr_err(src_addr, ADDR_W);
    assign enter_resp = (accept && NO_WAIT) || ((state_q == ST_WAIT) && (cnt_q == '0));
    assign ram_we     = enter_resp && src_we && !src_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = NO_WAIT ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_LD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
            end
            if (enter_resp) begin
                err_q   <= src_err;
                rdata_q <= (!src_we && !src_err) ? ram_rdata : 32'd0;
            end else if (state_q == ST_RESP) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    dm_ram_be #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i      (clk_i),
        .we_i       (ram_we),
        .addr_i     (src_addr[ADDR_W+1:2]),
        .wdata_i    (src_wdata),
        .be_i       (src_be),
        .rdata_o    (ram_rdata),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o)
    );

    assign bus.gnt    = gnt;
    assign bus.rvalid = (state_q == ST_RESP);
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder. Instance A (WAIT=2)
//               runs table vectors, random traffic against a word-array
//               reference model, and a reset-during-wait sequence. Instance B
//               (WAIT=0) checks back-to-back throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

    localparam int AW     = 10;
    localparam int WAIT_A = 2;
    localparam int WORDS  = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data_a;
    logic [31:0]   dbg_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [WORDS];

    dm_responder_if ifa ();
    dm_responder_if ifb ();

    dm_responder #(.ADDR_W(AW), .WAIT(WAIT_A)) u_dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (ifa),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data_a)
    );

    dm_responder #(.ADDR_W(AW), .WAIT(0)) u_dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (ifb),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed rules computed with plain arithmetic.
    function automatic logic model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * WORDS));
    endfunction

    task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, output logic [31:0] exp_rd,
                               output logic exp_er);
        int w;
        exp_er = model_err(a);
        exp_rd = 32'd0;
        w = int'(a / 4);
        if (!exp_er) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rd = model_mem[w];
            end
        end
    endtask

    // One transaction on instance A; checks latency and post-response clear.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic er);
        int n;
        ifa.req = 1'b1; ifa.we = we; ifa.addr = addr; ifa.wdata = wdata; ifa.be = be;
        #1;
        n = 0;
        while (ifa.gnt !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_gnt", {31'd0, ifa.gnt}, 32'd1);
        @(negedge clk);
        ifa.req = 1'b0;
        #1;
        n = 1;
        while (ifa.rvalid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(WAIT_A + 1));
        rd = ifa.rdata;
        er = ifa.err;
        @(negedge clk); #1;
        chk("rvalid_pulse", {31'd0, ifa.rvalid}, 32'd0);
        chk("rdata_clear", ifa.rdata, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [7];
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          known [$];

        ifa.req = 0; ifa.we = 0; ifa.addr = 0; ifa.wdata = 0; ifa.be = 0;
        ifb.req = 0; ifb.we = 0; ifb.addr = 0; ifb.wdata = 0; ifb.be = 0;
        dbg_addr = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", {31'd0, ifa.gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, ifa.rvalid}, 32'd0);
        chk("rst_rdata", ifa.rdata, 32'd0);
        chk("rst_err", {31'd0, ifa.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_gnt", {31'd0, ifa.gnt}, 32'd1);

        // Give the low words and the last word defined contents.
        for (int w = 0; w < 16; w++) known.push_back(w);
        known.push_back(WORDS - 1);
        foreach (known[k]) begin
            do_txn(1'b1, 32'(known[k] * 4), 32'hA500_0000 | 32'(known[k]), 4'hF, rd, er);
            model_apply(1'b1, 32'(known[k] * 4), 32'hA500_0000 | 32'(known[k]), 4'hF, exp_rd, exp_er);
            chk("init_err", {31'd0, er}, 32'd0);
        end

        // Directed table
        tbl[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h10,   32'h0000AA00, 4'h2, 32'h0,        1'b0};
        tbl[3] = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
        tbl[4] = '{1'b1, 32'h12,   32'h12345678, 4'hF, 32'h0,        1'b1};
        tbl[5] = '{1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[6] = '{1'b0, 32'hFFC,  32'h0,        4'hF, 32'hA50003FF, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er);
            model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, exp_rd, exp_er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            if (i == 4) begin
                dbg_addr = AW'(4);
                #1;
                chk("dbg_after_misaligned", dbg_data_a, 32'hDEADAAEF);
            end
        end

        // Randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [31:0] a, wd;
            logic [3:0]  be;
            int          kind, w;
            kind = int'($urandom_range(0, 9));
            w    = int'($urandom_range(0, 15));
            case (kind)
                6:       a = 32'(w * 4) + 32'($urandom_range(1, 3));
                7:       a = 32'h1000 + 32'(w * 4);
                8:       a = 32'hFFC;
                9:       a = 32'h8000_0000 | 32'(w * 4);
                default: a = 32'(w * 4);
            endcase
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            model_apply(we, a, wd, be, exp_rd, exp_er);
            do_txn(we, a, wd, be, rd, er);
            chk($sformatf("rnd%0d_rdata a=%h we=%0d", t, a, we), rd, exp_rd);
            chk($sformatf("rnd%0d_err a=%h", t, a), {31'd0, er}, {31'd0, exp_er});
        end

        // Reset while a write is waiting: the write must be dropped.
        ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h14; ifa.wdata = 32'h11111111; ifa.be = 4'hF;
        #1;
        chk("rstwait_gnt", {31'd0, ifa.gnt}, 32'd1);
        @(negedge clk);
        ifa.req = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rstwait_gnt_low", {31'd0, ifa.gnt}, 32'd0);
            chk("rstwait_no_rvalid", {31'd0, ifa.rvalid}, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rstwait_gnt_release", {31'd0, ifa.gnt}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("rstwait_no_rvalid_after", {31'd0, ifa.rvalid}, 32'd0);
            @(negedge clk); #1;
        end
        dbg_addr = AW'(5);
        #1;
        chk("rstwait_word_unchanged", dbg_data_a, model_mem[5]);

        // Zero wait states: back-to-back on instance B
        @(negedge clk);
        ifb.req = 1'b1; ifb.we = 1'b0; ifb.addr = 32'h0; ifb.be = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("b2b_gnt_c%0d", c), {31'd0, ifb.gnt}, {31'd0, (c % 2 == 0)});
            chk($sformatf("b2b_rvalid_c%0d", c), {31'd0, ifb.rvalid}, {31'd0, (c % 2 == 1)});
            if (c % 2 == 1) chk($sformatf("b2b_err_c%0d", c), {31'd0, ifb.err}, 32'd0);
            @(negedge clk);
        end
        ifb.req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
